// File: rtl/ssrv_mem_resp_if.sv
// ssrv_mem_resp_if: fetch (imem) and load/store (dmem) port bundle between
// the SSRV core (master) and the unified memory responder (slave).
interface ssrv_mem_resp_if #(
  parameter int XLEN    = 32,
  parameter int BUS_WID = 64
) ();
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic [BUS_WID-1:0] imem_rdata;
  logic               imem_resp;

  logic               dmem_req;
  logic               dmem_cmd;
  logic [1:0]         dmem_width;
  logic [XLEN-1:0]    dmem_addr;
  logic [XLEN-1:0]    dmem_wdata;
  logic [XLEN-1:0]    dmem_rdata;
  logic               dmem_resp;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/ssrv_mem_resp.sv
// ssrv_mem_resp: unified word-organised instruction/data RAM for the SSRV
// core. The imem port returns BUS_WID-wide aligned lines, the dmem port
// performs byte/half/word writes and full-word reads. Each port has its own
// fixed-latency {valid,data} pipeline (LAT_I / LAT_D stages, 1..4).
// Optional feature: define SSRV_MEM_BACKDOOR_EN to add a backdoor word loader
// (bd_we / bd_addr / bd_wdata) that produces no response.
module ssrv_mem_resp #(
  parameter int MEM_AW  = 14,
  parameter int LAT_I   = 1,
  parameter int LAT_D   = 1,
  parameter int XLEN    = 32,
  parameter int BUS_WID = 64
) (
  input  logic              clk,
  input  logic              rst,
  ssrv_mem_resp_if.slave    bus
`ifdef SSRV_MEM_BACKDOOR_EN
  ,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [31:0]       bd_wdata
`endif
);

  localparam int W     = BUS_WID / 32;
  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0] r_mem [DEPTH];

  // Acceptance: nothing is taken while reset is held
  logic w_i_acc;
  logic w_d_acc;
  logic w_d_wr;
  assign w_i_acc = bus.imem_req & ~rst;
  assign w_d_acc = bus.dmem_req & ~rst;
  assign w_d_wr  = w_d_acc & bus.dmem_cmd;

  // Word indices; upper address bits are dropped so accesses alias modulo capacity
  logic [MEM_AW-1:0] w_i_base;
  logic [MEM_AW-1:0] w_d_idx;
  assign w_i_base = bus.imem_addr[MEM_AW+1:2] & ~(MEM_AW'(W - 1));
  assign w_d_idx  = bus.dmem_addr[MEM_AW+1:2];

  // Address bits that do not select a word are intentionally ignored
  logic w_unused;
  assign w_unused = ^{bus.imem_addr[XLEN-1:MEM_AW+2], bus.imem_addr[1:0],
                      bus.dmem_addr[XLEN-1:MEM_AW+2]};

  // Gather the W words of the fetch line; index arithmetic wraps at capacity
  logic [BUS_WID-1:0] w_i_line;
  always_comb begin
    w_i_line = '0;
    for (int k = 0; k < W; k++) begin
      w_i_line[32*k +: 32] = r_mem[w_i_base + MEM_AW'(k)];
    end
  end

  // Old word at the dmem index; same-cycle writes are not yet visible here
  logic [31:0] w_d_rword;
  assign w_d_rword = r_mem[w_d_idx];

  // Byte enables and lane-replicated write data; misaligned halves/words
  // simply land in their aligned container
  logic [3:0]  w_d_be;
  logic [31:0] w_d_wdata;
  always_comb begin
    w_d_be    = 4'b0000;
    w_d_wdata = 32'h0000_0000;
    case (bus.dmem_width)
      2'd0: begin
        w_d_be    = 4'b0001 << bus.dmem_addr[1:0];
        w_d_wdata = {4{bus.dmem_wdata[7:0]}};
      end
      2'd1: begin
        if (bus.dmem_addr[1]) begin
          w_d_be = 4'b1100;
        end else begin
          w_d_be = 4'b0011;
        end
        w_d_wdata = {2{bus.dmem_wdata[15:0]}};
      end
      default: begin
        w_d_be    = 4'b1111;
        w_d_wdata = bus.dmem_wdata[31:0];
      end
    endcase
  end

  // Array update; the backdoor goes first so enabled dmem lanes override it
  always_ff @(posedge clk) begin
`ifdef SSRV_MEM_BACKDOOR_EN
    if (bd_we) begin
      r_mem[bd_addr] <= bd_wdata;
    end
`endif
    if (w_d_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_d_be[b]) begin
          r_mem[w_d_idx][8*b +: 8] <= w_d_wdata[8*b +: 8];
        end
      end
    end
  end

  // imem response pipeline; data stages load only behind a valid so the
  // output holds its last line between responses
  logic [LAT_I-1:0]              r_i_vld;
  logic [LAT_I-1:0][BUS_WID-1:0] r_i_dat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_vld <= '0;
      r_i_dat <= '0;
    end else begin
      r_i_vld[0] <= w_i_acc;
      if (w_i_acc) begin
        r_i_dat[0] <= w_i_line;
      end
      for (int s = 1; s < LAT_I; s++) begin
        r_i_vld[s] <= r_i_vld[s-1];
        if (r_i_vld[s-1]) begin
          r_i_dat[s] <= r_i_dat[s-1];
        end
      end
    end
  end

  // dmem response pipeline; writes also respond, carrying the pre-write word
  logic [LAT_D-1:0]           r_d_vld;
  logic [LAT_D-1:0][XLEN-1:0] r_d_dat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_vld <= '0;
      r_d_dat <= '0;
    end else begin
      r_d_vld[0] <= w_d_acc;
      if (w_d_acc) begin
        r_d_dat[0] <= XLEN'(w_d_rword);
      end
      for (int s = 1; s < LAT_D; s++) begin
        r_d_vld[s] <= r_d_vld[s-1];
        if (r_d_vld[s-1]) begin
          r_d_dat[s] <= r_d_dat[s-1];
        end
      end
    end
  end

  assign bus.imem_resp  = r_i_vld[LAT_I-1];
  assign bus.imem_rdata = r_i_dat[LAT_I-1];
  assign bus.dmem_resp  = r_d_vld[LAT_D-1];
  assign bus.dmem_rdata = r_d_dat[LAT_D-1];

endmodule

// File: tb/tb_ssrv_mem_resp.sv
// tb_ssrv_mem_resp: directed test of the unified memory responder with
// LAT_I=2, LAT_D=3 and a 64-bit fetch line.
module tb_ssrv_mem_resp;
  localparam int MEM_AW = 14;
  localparam int LAT_I  = 2;
  localparam int LAT_D  = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;

`ifdef SSRV_MEM_BACKDOOR_EN
  logic              bd_we;
  logic [MEM_AW-1:0] bd_addr;
  logic [31:0]       bd_wdata;
  initial begin
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_wdata = 32'h0;
  end
`endif

  ssrv_mem_resp_if #(.XLEN(32), .BUS_WID(64)) bus ();

  ssrv_mem_resp #(
    .MEM_AW (MEM_AW),
    .LAT_I  (LAT_I),
    .LAT_D  (LAT_D),
    .XLEN   (32),
    .BUS_WID(64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef SSRV_MEM_BACKDOOR_EN
    ,
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_wdata(bd_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter: value seen at a negedge = number of rising edges so far
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed responses
  int          dq_cyc[$];
  logic [31:0] dq_dat[$];
  int          iq_cyc[$];
  logic [63:0] iq_dat[$];
  // expected responses
  int          ed_cyc[$];
  logic [31:0] ed_dat[$];
  bit          ed_cd[$];
  int          ei_cyc[$];
  logic [63:0] ei_dat[$];

  always @(negedge clk) begin
    if (bus.imem_resp === 1'b1) begin
      iq_cyc.push_back(cyc);
      iq_dat.push_back(bus.imem_rdata);
    end
    if (bus.dmem_resp === 1'b1) begin
      dq_cyc.push_back(cyc);
      dq_dat.push_back(bus.dmem_rdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
  endtask

  // drive a dmem request for the next edge; edat is checked only for reads
  task automatic d_op(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] edat);
    bus.dmem_req   = 1'b1;
    bus.dmem_cmd   = cmd;
    bus.dmem_width = width;
    bus.dmem_addr  = addr;
    bus.dmem_wdata = wdata;
    ed_cyc.push_back(cyc + LAT_D);
    ed_dat.push_back(edat);
    ed_cd.push_back(~cmd);
  endtask

  task automatic i_op(input logic [31:0] addr, input logic [63:0] edat);
    bus.imem_req  = 1'b1;
    bus.imem_addr = addr;
    ei_cyc.push_back(cyc + LAT_I);
    ei_dat.push_back(edat);
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (LAT_I + LAT_D + 2) step();
    check({tag, "_dcnt"}, 64'(dq_cyc.size()), 64'(ed_cyc.size()));
    n = (dq_cyc.size() < ed_cyc.size()) ? dq_cyc.size() : ed_cyc.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_d%0d_cyc", tag, i), 64'(dq_cyc[i]), 64'(ed_cyc[i]));
      if (ed_cd[i]) begin
        check($sformatf("%s_d%0d_dat", tag, i), 64'(dq_dat[i]), 64'(ed_dat[i]));
      end
    end
    check({tag, "_icnt"}, 64'(iq_cyc.size()), 64'(ei_cyc.size()));
    n = (iq_cyc.size() < ei_cyc.size()) ? iq_cyc.size() : ei_cyc.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_i%0d_cyc", tag, i), 64'(iq_cyc[i]), 64'(ei_cyc[i]));
      check($sformatf("%s_i%0d_dat", tag, i), iq_dat[i], ei_dat[i]);
    end
    dq_cyc.delete(); dq_dat.delete(); iq_cyc.delete(); iq_dat.delete();
    ed_cyc.delete(); ed_dat.delete(); ed_cd.delete(); ei_cyc.delete(); ei_dat.delete();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.imem_req   = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.dmem_req   = 1'b0;
    bus.dmem_cmd   = 1'b0;
    bus.dmem_width = 2'd0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iresp", 64'(bus.imem_resp), 64'd0);
    check("rst_dresp", 64'(bus.dmem_resp), 64'd0);
    check("rst_irdata", bus.imem_rdata, 64'd0);
    check("rst_drdata", 64'(bus.dmem_rdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // word round trip
    d_op(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 32'h0); step();
    d_op(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEAD_BEEF); step();
    drain("rt");

    // byte lanes, misaligned forcing, width 3 behaves as word
    d_op(1'b1, 2'd2, 32'h200, 32'h0000_0000, 32'h0); step();
    d_op(1'b1, 2'd0, 32'h203, 32'h0000_00AB, 32'h0); step();
    d_op(1'b1, 2'd1, 32'h200, 32'h0000_1234, 32'h0); step();
    d_op(1'b1, 2'd2, 32'h300, 32'h0000_0000, 32'h0); step();
    d_op(1'b1, 2'd1, 32'h301, 32'h0000_5678, 32'h0); step();
    d_op(1'b1, 2'd0, 32'h302, 32'hFFFF_FFCD, 32'h0); step();
    d_op(1'b1, 2'd3, 32'h402, 32'hCAFE_F00D, 32'h0); step();
    d_op(1'b1, 2'd2, 32'h304, 32'h0000_0000, 32'h0); step();
    d_op(1'b1, 2'd1, 32'h306, 32'h1111_BEEF, 32'h0); step();
    d_op(1'b0, 2'd2, 32'h200, 32'h0, 32'hAB00_1234); step();
    d_op(1'b0, 2'd0, 32'h302, 32'h0, 32'h00CD_5678); step();
    d_op(1'b0, 2'd1, 32'h401, 32'h0, 32'hCAFE_F00D); step();
    d_op(1'b0, 2'd2, 32'h304, 32'h0, 32'hBEEF_0000); step();
    drain("lanes");

    // fetch line, including an aliased fetch one capacity higher
    d_op(1'b1, 2'd2, 32'h0, 32'h1111_1111, 32'h0); step();
    d_op(1'b1, 2'd2, 32'h4, 32'h2222_2222, 32'h0); step();
    i_op(32'h4, 64'h2222_2222_1111_1111); step();
    i_op(32'h0, 64'h2222_2222_1111_1111); step();
    i_op(32'h0001_0004, 64'h2222_2222_1111_1111); step();
    drain("fetch");

    // back-to-back reads with a wrapping address
    d_op(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEAD_BEEF); step();
    d_op(1'b0, 2'd2, 32'h4, 32'h0, 32'h2222_2222); step();
    d_op(1'b0, 2'd2, 32'h0001_0000, 32'h0, 32'h1111_1111); step();
    d_op(1'b0, 2'd2, 32'h200, 32'h0, 32'hAB00_1234); step();
    drain("pipe");

    // same-cycle fetch/write collision
    d_op(1'b1, 2'd2, 32'h8, 32'h7777_7777, 32'h0); step();
    d_op(1'b1, 2'd2, 32'hC, 32'h8888_8888, 32'h0); step();
    d_op(1'b1, 2'd2, 32'h8, 32'h0000_0005, 32'h0);
    i_op(32'h8, 64'h8888_8888_7777_7777); step();
    i_op(32'h8, 64'h8888_8888_0000_0005); step();
    drain("coll");

    // reset mid-flight: fetch plus committing write, then reset one cycle later
    d_op(1'b1, 2'd2, 32'h600, 32'h0000_AAAA, 32'h0); step();
    drain("pre_rst");
    bus.imem_req   = 1'b1;
    bus.imem_addr  = 32'h0;
    bus.dmem_req   = 1'b1;
    bus.dmem_cmd   = 1'b1;
    bus.dmem_width = 2'd2;
    bus.dmem_addr  = 32'h500;
    bus.dmem_wdata = 32'h0000_0999;
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.imem_req   = 1'b0;
    bus.dmem_addr  = 32'h600;
    bus.dmem_wdata = 32'h0000_BBBB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_iresp", 64'(bus.imem_resp), 64'd0);
    check("mid_dresp", 64'(bus.dmem_resp), 64'd0);
    check("mid_irdata", bus.imem_rdata, 64'd0);
    check("mid_drdata", 64'(bus.dmem_rdata), 64'd0);
    bus.dmem_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT_I + LAT_D + 2) step();
    check("mid_no_iresp", 64'(iq_cyc.size()), 64'd0);
    check("mid_no_dresp", 64'(dq_cyc.size()), 64'd0);
    iq_cyc.delete(); iq_dat.delete(); dq_cyc.delete(); dq_dat.delete();
    d_op(1'b0, 2'd2, 32'h500, 32'h0, 32'h0000_0999); step();
    d_op(1'b0, 2'd2, 32'h600, 32'h0, 32'h0000_AAAA); step();
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ssrv_mem_resp.md
# ssrv_mem_resp

Unified instruction/data memory responder serving the two initiator ports of the SSRV core: the `imem_*` fetch port and the `dmem_*` load/store port. It sits in the SoC and simulation top beside `ssrv_top`, wired port-to-port. A single word-organised RAM array serves both ports, and each port has its own fixed-latency response pipeline.

## Interface
- `MEM_AW`, 14: word-address width; capacity is 2^MEM_AW 32-bit words (default 64 KiB).
- `LAT_I`, 1: imem response latency in cycles; legal range 1..4.
- `LAT_D`, 1: dmem response latency in cycles; legal range 1..4.
- `clk` in 1: the single clock; every register updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` in 1: fetch request; one request is accepted per cycle in which this is high.
- `imem_addr` in `XLEN`: fetch byte address.
- `imem_rdata` out `BUS_WID`: fetched line.
- `imem_resp` out 1: fetch response valid, one-cycle pulse per request.
- `dmem_req` in 1: data request; one request is accepted per cycle in which this is high.
- `dmem_cmd` in 1: 1 = write, 0 = read.
- `dmem_width` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = word.
- `dmem_addr` in `XLEN`: data byte address.
- `dmem_wdata` in `XLEN`: write data, right-aligned.
- `dmem_rdata` out `XLEN`: read data, the full aligned word.
- `dmem_resp` out 1: data response valid, one pulse per request (reads and writes).

## Operation
- Array index is `addr[MEM_AW+1:2]`. Upper address bits are ignored, so accesses alias and wrap modulo capacity.
- **Fetch**
  - Line width is W = `BUS_WID`/32 words.
  - The line base is `imem_addr` rounded down to a multiple of W×4 bytes.
  - Word k of the line goes in `imem_rdata[32k+31:32k]`.
  - If the line index runs past the last word, it wraps to word 0.
- **Read**
  - Returns the whole word at `addr[MEM_AW+1:2]`, regardless of width and `addr[1:0]`.
  - Lane extraction and sign extension are done by the core.
- **Write**
  - Byte enables are derived from width and `addr[1:0]`. Byte: lane `addr[1:0]`. Half: lanes `{addr[1],0}` and `{addr[1],1}`. Word: all four lanes.
  - Data is shifted from right-aligned `dmem_wdata` into those lanes.
  - Misaligned half/word accesses (a half with `addr[0]=1`, a word with `addr[1:0]≠0`) are forced to the aligned container. No error is flagged.
- Each port holds an independent shift pipeline of {valid, data}, `LAT_x` stages deep. The array is read at acceptance and the result is carried down the pipeline.
- **Same-cycle collisions**
  - A read (imem or dmem) accepted in the same cycle as a dmem write to the same word returns the old contents.
  - Writes accepted in earlier cycles are always visible.
- Back-to-back requests every cycle are fully pipelined: no bubbles, responses in request order.
- Array contents are not affected by `rst`.

## Timing
- A request accepted at edge n produces its response pulse during the cycle after edge n+`LAT_x`−1 (for `LAT_x`=1, the cycle right after acceptance).
- `*_resp` and `*_rdata` are registered outputs. `*_rdata` is valid only while `*_resp`=1 and holds its last value otherwise.
- A write commits to the array at its acceptance edge. Its `dmem_resp` data field carries the pre-write word and must be ignored by the core.
- On reset assertion (asynchronous): `imem_resp`=0, `dmem_resp`=0, `imem_rdata`=0, `dmem_rdata`=0, all pipeline valids cleared.
  - In-flight requests are dropped and never responded to.
  - A write accepted at the last edge before reset has already committed.
- No requests are accepted while `rst`=1.

## Configuration
- `SSRV_MEM_BACKDOOR_EN` defined: adds a backdoor loader port.
  - Ports: `bd_we` in 1, `bd_addr` in `MEM_AW` (word index), `bd_wdata` in 32.
  - A full-word write is performed at the edge where `bd_we`=1.
  - On a same-cycle collision with a dmem write to the same word, the dmem write wins on its enabled bytes and the backdoor write supplies the rest.
  - Backdoor writes produce no response.
- Undefined: these ports do not exist, and the array is written only through `dmem`.

## Test plan
- **Word round trip.** Write 0xDEADBEEF to 0x100 as a word, then read 0x100 → `dmem_resp` `LAT_D` cycles after each request; read data 0xDEADBEEF.
- **Byte lanes.** Word 0x00000000 at 0x200, then a byte write of 0xAB at 0x203 and a half write of 0x1234 at 0x200 → word read returns 0xAB001234.
- **Fetch line.** With `BUS_WID`=64, words 0x11111111 at 0x0 and 0x22222222 at 0x4, fetch at 0x4 → `imem_rdata`=0x2222222211111111.
- **Pipelining and wrap.** `LAT_D`=3, four consecutive reads including address 4×2^MEM_AW, which aliases word 0 → four consecutive resp pulses in order, starting 3 cycles after the first request.
- **Collision.** Fetch and dmem write of 0x5 to the same word in the same cycle → fetch returns the old word; a fetch the next cycle returns 0x5.
- **Reset mid-flight.** `LAT_I`=2, assert `rst` one cycle after `imem_req` → `imem_resp` never pulses and all outputs read 0 during reset.
